// File: rtl/eaf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eaf_pkg
// Brief    : Shared types and array geometry for the EAF Bloom filter.
// Revision : 1.0 - initial release
// ============================================================================
package eaf_pkg;

  typedef enum logic {
    OP_TEST   = 1'b0,
    OP_INSERT = 1'b1
  } eaf_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } eaf_state_t;

  localparam int SIZE1  = 2;
  localparam int SIZE2  = 4;
  localparam int SIZE3  = 8;
  localparam int SIZE5  = 32;
  localparam int SIZE7  = 128;
  localparam int SIZE11 = 2048;
  localparam int SIZE13 = 8192;

  localparam int IDX1_W  = 1;
  localparam int IDX2_W  = 2;
  localparam int IDX3_W  = 3;
  localparam int IDX5_W  = 5;
  localparam int IDX7_W  = 7;
  localparam int IDX11_W = 11;
  localparam int IDX13_W = 13;

  // Sweep length is set by the largest array: 8192 bits / 64-bit words.
  localparam int CLR_CYCLES = 128;
  localparam int CLR_IDX_W  = $clog2(CLR_CYCLES);

endpackage
`default_nettype wire

// File: rtl/eaf_bit_array.sv
`default_nettype none
// ============================================================================
// Module   : eaf_bit_array
// Brief    : One Bloom bit array: set-on-index, combinational read, word clear.
// Revision : 1.0 - initial release
// ============================================================================
module eaf_bit_array
  import eaf_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int IDX_W      = $clog2(SIZE),
  parameter int CLR_WORD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [IDX_W-1:0]     set_idx,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_bit,
  input  logic                 clr_en,
  input  logic [CLR_IDX_W-1:0] clr_idx
);

  logic [SIZE-1:0] r_bits;
  logic [SIZE-1:0] w_set_mask;
  logic [SIZE-1:0] w_clr_mask;

  assign w_set_mask = set_en ? (SIZE'(1) << set_idx) : '0;

  // Arrays no wider than one sweep word are wiped whole on the first sweep step.
  generate
    if (SIZE <= CLR_WORD_W) begin : g_whole
      assign w_clr_mask = {SIZE{clr_en && (clr_idx == '0)}};
    end else begin : g_words
      for (genvar w = 0; w < SIZE / CLR_WORD_W; w++) begin : g_word
        assign w_clr_mask[w*CLR_WORD_W +: CLR_WORD_W] =
          {CLR_WORD_W{clr_en && (clr_idx == CLR_IDX_W'(w))}};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bits <= '0;
    end else begin
      r_bits <= (r_bits | w_set_mask) & ~w_clr_mask;
    end
  end

  assign rd_bit = r_bits[rd_idx];

endmodule
`default_nettype wire

// File: rtl/eaf_bloom_filter.sv
`default_nettype none
// ============================================================================
// Module   : eaf_bloom_filter
// Brief    : Seven-array evicted-address Bloom filter with auto-clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module eaf_bloom_filter
  import eaf_pkg::*;
#(
  parameter int MAX_INSERTS = 16,
  parameter int CNT_W       = 5,
  parameter int CLR_WORD_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_op,
  input  logic               idx1,
  input  logic [1:0]         idx2,
  input  logic [2:0]         idx3,
  input  logic [4:0]         idx5,
  input  logic [6:0]         idx7,
  input  logic [10:0]        idx11,
  input  logic [12:0]        idx13,
  input  logic               clear_i,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [CNT_W-1:0]   ins_count,
  output logic               busy
);

  localparam logic [CNT_W-1:0]     c_cnt_last = CNT_W'(MAX_INSERTS - 1);
  localparam logic [CLR_IDX_W-1:0] c_clr_last = CLR_IDX_W'(CLR_CYCLES - 1);

  eaf_state_t           r_state;
  logic [CLR_IDX_W-1:0] r_clr_idx;
  logic [CNT_W-1:0]     r_ins_count;
  logic                 r_s1_valid;
  eaf_op_t              r_s1_op;
  logic                 r_s1_idx1;
  logic [1:0]           r_s1_idx2;
  logic [2:0]           r_s1_idx3;
  logic [4:0]           r_s1_idx5;
  logic [6:0]           r_s1_idx7;
  logic [10:0]          r_s1_idx11;
  logic [12:0]          r_s1_idx13;

  logic [6:0] w_bit;
  logic       w_hit;
  logic       w_s1_insert;
  logic       w_novel;
  logic       w_clearing;
  logic       w_accept;

  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_s1_insert = r_s1_valid && (r_s1_op == OP_INSERT);
  assign w_hit       = r_s1_valid && (&w_bit);
  assign w_novel     = w_s1_insert && !(&w_bit);
  // Hold off a request that could land while the last novel insert trips the clear.
  assign req_ready   = !w_clearing && !clear_i && !(w_s1_insert && (r_ins_count == c_cnt_last));
  assign w_accept    = req_valid && req_ready;

  assign resp_valid = r_s1_valid;
  assign resp_hit   = w_hit;
  assign ins_count  = r_ins_count;
  assign busy       = w_clearing;

  eaf_bit_array #(.SIZE(SIZE1), .IDX_W(IDX1_W), .CLR_WORD_W(CLR_WORD_W)) u_arr1 (
    .clk(clk), .rst(rst), .set_en(w_s1_insert), .set_idx(r_s1_idx1), .rd_idx(r_s1_idx1),
    .rd_bit(w_bit[0]), .clr_en(w_clearing), .clr_idx(r_clr_idx));
  eaf_bit_array #(.SIZE(SIZE2), .IDX_W(IDX2_W), .CLR_WORD_W(CLR_WORD_W)) u_arr2 (
    .clk(clk), .rst(rst), .set_en(w_s1_insert), .set_idx(r_s1_idx2), .rd_idx(r_s1_idx2),
    .rd_bit(w_bit[1]), .clr_en(w_clearing), .clr_idx(r_clr_idx));
  eaf_bit_array #(.SIZE(SIZE3), .IDX_W(IDX3_W), .CLR_WORD_W(CLR_WORD_W)) u_arr3 (
    .clk(clk), .rst(rst), .set_en(w_s1_insert), .set_idx(r_s1_idx3), .rd_idx(r_s1_idx3),
    .rd_bit(w_bit[2]), .clr_en(w_clearing), .clr_idx(r_clr_idx));
  eaf_bit_array #(.SIZE(SIZE5), .IDX_W(IDX5_W), .CLR_WORD_W(CLR_WORD_W)) u_arr5 (
    .clk(clk), .rst(rst), .set_en(w_s1_insert), .set_idx(r_s1_idx5), .rd_idx(r_s1_idx5),
    .rd_bit(w_bit[3]), .clr_en(w_clearing), .clr_idx(r_clr_idx));
  eaf_bit_array #(.SIZE(SIZE7), .IDX_W(IDX7_W), .CLR_WORD_W(CLR_WORD_W)) u_arr7 (
    .clk(clk), .rst(rst), .set_en(w_s1_insert), .set_idx(r_s1_idx7), .rd_idx(r_s1_idx7),
    .rd_bit(w_bit[4]), .clr_en(w_clearing), .clr_idx(r_clr_idx));
  eaf_bit_array #(.SIZE(SIZE11), .IDX_W(IDX11_W), .CLR_WORD_W(CLR_WORD_W)) u_arr11 (
    .clk(clk), .rst(rst), .set_en(w_s1_insert), .set_idx(r_s1_idx11), .rd_idx(r_s1_idx11),
    .rd_bit(w_bit[5]), .clr_en(w_clearing), .clr_idx(r_clr_idx));
  eaf_bit_array #(.SIZE(SIZE13), .IDX_W(IDX13_W), .CLR_WORD_W(CLR_WORD_W)) u_arr13 (
    .clk(clk), .rst(rst), .set_en(w_s1_insert), .set_idx(r_s1_idx13), .rd_idx(r_s1_idx13),
    .rd_bit(w_bit[6]), .clr_en(w_clearing), .clr_idx(r_clr_idx));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_clr_idx   <= '0;
      r_ins_count <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_op     <= OP_TEST;
      r_s1_idx1   <= '0;
      r_s1_idx2   <= '0;
      r_s1_idx3   <= '0;
      r_s1_idx5   <= '0;
      r_s1_idx7   <= '0;
      r_s1_idx11  <= '0;
      r_s1_idx13  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op    <= eaf_op_t'(req_op);
        r_s1_idx1  <= idx1;
        r_s1_idx2  <= idx2;
        r_s1_idx3  <= idx3;
        r_s1_idx5  <= idx5;
        r_s1_idx7  <= idx7;
        r_s1_idx11 <= idx11;
        r_s1_idx13 <= idx13;
      end
      case (r_state)
        ST_IDLE: begin
          r_clr_idx <= '0;
          if (clear_i || (w_novel && (r_ins_count == c_cnt_last))) begin
            r_state     <= ST_CLEAR;
            r_ins_count <= '0;
          end else if (w_novel) begin
            r_ins_count <= r_ins_count + CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + CLR_IDX_W'(1);
          if (r_clr_idx == c_clr_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eaf_bloom_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eaf_bloom_filter
// Brief    : Scoreboard bench for eaf_bloom_filter against a set-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eaf_bloom_filter;
  import eaf_pkg::*;

  localparam int MAX_INS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic        idx1 = '0;
  logic [1:0]  idx2 = '0;
  logic [2:0]  idx3 = '0;
  logic [4:0]  idx5 = '0;
  logic [6:0]  idx7 = '0;
  logic [10:0] idx11 = '0;
  logic [12:0] idx13 = '0;
  logic        clear_i = 1'b0;
  logic        resp_valid;
  logic        resp_hit;
  logic [4:0]  ins_count;
  logic        busy;

  eaf_bloom_filter #(.MAX_INSERTS(MAX_INS), .CNT_W(5), .CLR_WORD_W(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .idx1(idx1), .idx2(idx2), .idx3(idx3), .idx5(idx5), .idx7(idx7), .idx11(idx11),
    .idx13(idx13), .clear_i(clear_i), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .ins_count(ins_count), .busy(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] i13;
    logic [10:0] i11;
    logic [6:0]  i7;
    logic [4:0]  i5;
    logic [2:0]  i3;
    logic [1:0]  i2;
    logic        i1;
  } idx_t;

  typedef struct {
    bit hit;
    int cnt;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   busy_start = -1000;
  int   mcount = 0;
  bit   pend_ins = 0;
  int   pend_cnt = 0;
  bit   auto_fired = 0;
  logic last_busy = 1'b0;
  bit   mdl[7][8192];
  idx_t pool[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Bloom membership: an entry is present iff every addressed bit is set.
  function automatic bit mdl_lookup(input idx_t x);
    return mdl[0][x.i1] && mdl[1][x.i2] && mdl[2][x.i3] && mdl[3][x.i5] &&
           mdl[4][x.i7] && mdl[5][x.i11] && mdl[6][x.i13];
  endfunction

  function automatic void mdl_set(input idx_t x);
    mdl[0][x.i1] = 1; mdl[1][x.i2] = 1; mdl[2][x.i3] = 1; mdl[3][x.i5] = 1;
    mdl[4][x.i7] = 1; mdl[5][x.i11] = 1; mdl[6][x.i13] = 1;
  endfunction

  function automatic void mdl_wipe();
    foreach (mdl[a, b]) mdl[a][b] = 0;
  endfunction

  function automatic idx_t rand_idx();
    idx_t r;
    r.i1  = 1'($urandom_range(0, 1));
    r.i2  = 2'($urandom_range(0, 3));
    r.i3  = 3'($urandom_range(0, 7));
    r.i5  = 5'($urandom_range(0, 31));
    r.i7  = 7'($urandom_range(0, 127));
    r.i11 = 11'($urandom_range(0, 2047));
    r.i13 = 13'($urandom_range(0, 8191));
    return r;
  endfunction

  task automatic do_cycle(input bit v, input bit op, input idx_t x, input bit clr);
    bit exp_busy;
    bit exp_ready;
    bit hit;
    @(posedge clk);
    cyc++;
    #1;
    req_valid = v; req_op = op; clear_i = clr;
    idx1 = x.i1; idx2 = x.i2; idx3 = x.i3; idx5 = x.i5;
    idx7 = x.i7; idx11 = x.i11; idx13 = x.i13;
    @(negedge clk);
    exp_busy  = (cyc >= busy_start) && (cyc < busy_start + CLR_CYCLES);
    exp_ready = !exp_busy && !clr && !(pend_ins && pend_cnt == MAX_INS - 1);
    last_busy = busy;
    chk("busy", int'(busy), int'(exp_busy));
    chk("req_ready", int'(req_ready), int'(exp_ready));
    pend_ins = 0;
    if (clr && !exp_busy) begin
      mdl_wipe();
      mcount = 0;
      busy_start = cyc + 1;
    end else if (v && exp_ready) begin
      hit = mdl_lookup(x);
      sb.push_back('{hit: hit, cnt: mcount, due: cyc + 1});
      if (op) begin
        mdl_set(x);
        pend_ins = 1;
        pend_cnt = mcount;
        if (!hit) mcount++;
        if (mcount == MAX_INS) begin
          mcount = 0;
          mdl_wipe();
          busy_start = cyc + 2;
          auto_fired = 1;
        end
      end
    end
  endtask

  // Monitor: every response is matched to the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          chk("resp_cycle", cyc, e_mon.due);
          chk("resp_hit", int'(resp_hit), int'(e_mon.hit));
          chk("resp_count", int'(ins_count), e_mon.cnt);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("resp_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    idx_t z;
    idx_t a;
    idx_t b;
    int   n_busy;
    z = '0;
    a = '{i13: 13'h1ABC, i11: 11'd1500, i7: 7'd99, i5: 5'd17, i3: 3'd5, i2: 2'd3, i1: 1'b1};
    b = '{i13: 13'h0123, i11: 11'd7, i7: 7'd1, i5: 5'd2, i3: 3'd1, i2: 2'd0, i1: 1'b0};
    foreach (pool[k]) pool[k] = rand_idx();
    mdl_wipe();

    #12;
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_hit", int'(resp_hit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ins_count", int'(ins_count), 0);
    @(negedge clk);
    rst = 1'b1;

    do_cycle(1, 0, z, 0);
    do_cycle(1, 1, a, 0);
    do_cycle(1, 0, a, 0);
    do_cycle(1, 1, a, 0);
    do_cycle(0, 0, z, 0);
    chk("count_after_dup", int'(ins_count), 1);

    for (int k = 0; k < 100 && !auto_fired; k++) do_cycle(1, 1, rand_idx(), 0);
    chk("auto_clear_fired", int'(auto_fired), 1);
    n_busy = 0;
    repeat (132) begin
      do_cycle(0, 0, z, 0);
      if (last_busy) n_busy++;
    end
    chk("busy_cycles", n_busy, 128);
    chk("count_after_sweep", int'(ins_count), 0);
    do_cycle(1, 0, a, 0);
    do_cycle(0, 0, z, 0);

    do_cycle(1, 1, b, 0);
    do_cycle(1, 1, a, 0);
    do_cycle(0, 0, z, 0);
    do_cycle(1, 0, a, 1);
    do_cycle(0, 0, z, 0);
    chk("ext_clear_count", int'(ins_count), 0);
    repeat (40) do_cycle(0, 0, z, 0);

    rst = 1'b0;
    #1;
    chk("midsweep_rst_busy", int'(busy), 0);
    chk("midsweep_rst_ready", int'(req_ready), 1);
    chk("midsweep_rst_count", int'(ins_count), 0);
    mdl_wipe();
    mcount = 0;
    busy_start = -1000;
    pend_ins = 0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_cycle(1, 0, a, 0);
    do_cycle(1, 0, b, 0);
    do_cycle(0, 0, z, 0);

    repeat (400) begin
      bit v;
      bit op;
      bit clr;
      idx_t x;
      v   = ($urandom_range(0, 3) != 0);
      op  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 149) == 0);
      x   = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)] : rand_idx();
      do_cycle(v, op, x, clr);
    end
    repeat (3) do_cycle(0, 0, z, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eaf_bloom_filter.md
Name: eaf_bloom_filter

Overview:
- Responder side of the EAF hash interface: owns the seven Bloom-filter bit arrays indexed by EAF_hash_functions.
- Array sizes are 2, 4, 8, 32, 128, 2048 and 8192 bits.
- Accepts insert/test requests carrying the seven prime indices, sets or checks the addressed bits, and returns a hit flag.
- Clears itself after MAX_INSERTS novel insertions (evicted-address-filter semantics); sits between the hash stage and the cache replacement logic.

Parameters:
- MAX_INSERTS, 16, novel insertions before automatic clear
- CNT_W, 5, width of the insertion counter (holds 0..MAX_INSERTS)
- CLR_WORD_W, 64, bits cleared per array per cycle during a sweep

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the cycle req_valid && req_ready
- req_op  in  1  0 = TEST, 1 = INSERT
- idx1  in  1  index into 2-bit array
- idx2  in  2  index into 4-bit array
- idx3  in  3  index into 8-bit array
- idx5  in  5  index into 32-bit array
- idx7  in  7  index into 128-bit array
- idx11  in  11  index into 2048-bit array
- idx13  in  13  index into 8192-bit array
- clear_i  in  1  single-cycle pulse requesting a full clear
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  all seven addressed bits were set at lookup
- ins_count  out  CNT_W  current novel-insertion count
- busy  out  1  clear sweep in progress

Behaviour:
- Clock and reset: single clock clk; rst asynchronous, active-low.
- Reset values:
  - all array bits 0; ins_count 0; state IDLE
  - stage-1 valid 0; resp_valid 0; resp_hit 0; busy 0
  - no sweep is needed after reset.
- FSM states: IDLE, CLEAR.
- req_ready is 1 only when all of the following hold:
  - state == IDLE
  - clear_i == 0
  - NOT (stage-1 holds an INSERT && ins_count == MAX_INSERTS-1)
- Request accept: on the accepting edge, op and indices are registered into stage 1.
- Response cycle (next cycle):
  - array bits are read combinationally
  - resp_valid = 1
  - resp_hit = AND of the seven addressed bits
- Latency: exactly 1 cycle from accept to resp_valid. No response backpressure.
- INSERT:
  - at the end of the response cycle, all seven addressed bits are set.
  - if resp_hit == 0 (novel), ins_count increments.
  - duplicate inserts leave ins_count unchanged.
  - resp_hit reports pre-insert presence.
- Back-to-back operation: one request accepted per cycle. A request accepted on the edge that writes an INSERT sees that write, so an insert followed by a test of the same indices hits.
- Auto clear: when a novel INSERT brings ins_count to MAX_INSERTS, the FSM enters CLEAR on the following edge and ins_count resets to 0.
- External clear: clear_i in IDLE enters CLEAR on the next edge and ins_count resets to 0. clear_i in CLEAR is ignored.
- If clear_i coincides with req_valid, the clear wins and the request is not accepted.
- A stage-1 response pending when CLEAR is entered still completes normally.
- CLEAR state:
  - busy = 1; req_ready = 0.
  - a sweep counter clr_idx runs 0..127; each cycle, CLR_WORD_W-bit word clr_idx of every array with more than clr_idx words is zeroed.
  - arrays narrower than CLR_WORD_W are zeroed wholly at clr_idx 0.
  - after clr_idx == 127 the FSM returns to IDLE, giving exactly 128 busy cycles.
- Reset mid-sweep: immediately returns to IDLE with arrays zeroed.
- Index widths match array sizes, so no wrap or modulo occurs inside the block.

Decomposition:
- eaf_pkg holds:
  - eaf_op_t (TEST/INSERT)
  - eaf_state_t (IDLE/CLEAR)
  - array-size constants (2, 4, 8, 32, 128, 2048, 8192) and their index widths
  - CLR_CYCLES = 128
- Sub-module eaf_bit_array (parameter SIZE) provides: set-on-index, combinational read-at-index, word clear by clr_idx. It is instantiated seven times.

Test Plan:
- Reset, then TEST idx = all 0 → resp_valid one cycle after accept; resp_hit 0; ins_count 0; busy 0.
- INSERT idx13 = 0x1ABC (others 1, 3, 5, 17, 99, 1500), then TEST with the same indices on the next cycle → insert resp_hit 0, test resp_hit 1, ins_count 1.
- Repeat the same INSERT → resp_hit 1, ins_count stays 1.
- Insert 16 distinct index sets → after the 16th, busy = 1 for exactly 128 cycles with req_ready 0; ins_count 0; the first TEST afterwards → resp_hit 0.
- Assert clear_i together with req_valid → request not accepted; busy rises next cycle; ins_count 0.
- Assert rst low at sweep cycle 40 → busy 0 and state IDLE immediately; after release, req_ready 1 and all previously inserted entries miss.
